// File: rtl/seq_pkg.sv
// seq_pkg: shared types and default constants for the sequence generator.
//   seq_state_t   - FSM state encoding (GAP only present with SEQ_GEN_GAP_EN)
//   DEF_PAT_W     - default pattern length in bits
//   DEF_PAT_INIT  - default pattern loaded at reset (MSB sent first)
//   DEF_REP_W     - default width of the repeat count
//   DEF_GAP_CYC   - default idle cycles between repetitions
// Optional feature macro: SEQ_GEN_GAP_EN
package seq_pkg;

  localparam int         DEF_PAT_W    = 4;
  localparam logic [3:0] DEF_PAT_INIT = 4'b1101;
  localparam int         DEF_REP_W    = 4;
  localparam int         DEF_GAP_CYC  = 2;

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd3
  } seq_state_t;
`endif

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: parallel-load, MSB-first shift register.
//   clk   in   clock, rising edge
//   reset in   asynchronous active-high reset, clears the register
//   load  in   capture d
//   shift in   shift left by one, zero fill
//   clear in   force the register to zero (highest priority)
//   d     in   [W-1:0] parallel load value
//   msb   out  current serial bit (register MSB)
module seq_shift_reg
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] q;

  // Zero fill keeps msb at 0 once the pattern has drained, and clear
  // parks it at 0 between repetitions and while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: sends a stored PAT_W-bit pattern MSB-first on A,
// repeated rep times per start request.
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset
//   load    in   capture pat_in into the pattern register (IDLE only)
//   pat_in  in   [PAT_W-1:0] new pattern
//   start   in   begin transmission (IDLE only)
//   rep     in   [REP_W-1:0] repetition count, sampled with start
//   A       out  serial data, 0 when a_valid is low
//   a_valid out  A carries a pattern bit
//   busy    out  transmission in progress
//   done    out  one-cycle pulse after the final bit
// Optional feature macro: SEQ_GEN_GAP_EN inserts GAP_CYC idle cycles
// between repetitions; without it repetitions are back-to-back.
//
// state | meaning
// IDLE  | waiting for start, load accepted
// SEND  | shifting pattern bits onto A
// GAP   | idle cycles between repetitions (SEQ_GEN_GAP_EN only)
// DONE  | done pulse, back to IDLE next cycle
module sequence_generator
  import seq_pkg::*;
#(
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(DEF_PAT_INIT),
  parameter int               REP_W    = DEF_REP_W,
  parameter int               GAP_CYC  = DEF_GAP_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             start,
  input  logic [REP_W-1:0] rep,
  output logic             A,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PAT_W - 1);

  seq_state_t       state;
  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-1:0] pat_next;
  logic [REP_W-1:0] rep_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             last_bit;
  logic             more_reps;
  logic             sh_load;
  logic             sh_shift;
  logic             sh_clear;

`ifdef SEQ_GEN_GAP_EN
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  logic [GAP_W-1:0] gap_cnt;
`else
  // GAP_CYC has no effect in this build; the reference keeps the
  // parameter interface identical between builds.
  if (GAP_CYC < 0) begin : g_gap_cyc_unused
  end
`endif

  always_comb begin
    // A simultaneous load in IDLE wins over the stored pattern, so the
    // freshly loaded value is the one that gets sent.
    pat_next  = (state == IDLE && load) ? pat_in : pat_reg;
    accept    = (state == IDLE) && start && (rep != '0);
    last_bit  = (state == SEND) && (bit_cnt == BIT_LAST);
    more_reps = rep_cnt > REP_W'(1);
    sh_shift  = (state == SEND) && !last_bit;
`ifdef SEQ_GEN_GAP_EN
    sh_load   = accept || ((state == GAP) && (gap_cnt == '0));
    sh_clear  = last_bit;
`else
    sh_load   = accept || (last_bit && more_reps);
    sh_clear  = last_bit && !more_reps;
`endif
  end

  // A is the shifter MSB, itself a register; it is zero whenever the
  // shifter is cleared, so A is 0 outside of valid bit cycles.
  seq_shift_reg #(.W(PAT_W)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .clear (sh_clear),
    .d     (pat_next),
    .msb   (A)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pat_reg <= PAT_INIT;
      rep_cnt <= '0;
      bit_cnt <= '0;
      a_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) pat_reg <= pat_in;
          if (start) begin
            if (rep != '0) begin
              rep_cnt <= rep;
              bit_cnt <= '0;
              a_valid <= 1'b1;
              busy    <= 1'b1;
              state   <= SEND;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SEND: begin
          if (!last_bit) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else begin
            bit_cnt <= '0;
            if (rep_cnt != '0) rep_cnt <= rep_cnt - REP_W'(1);
            if (more_reps) begin
`ifdef SEQ_GEN_GAP_EN
              a_valid <= 1'b0;
              gap_cnt <= GAP_W'(GAP_CYC - 1);
              state   <= GAP;
`endif
            end else begin
              a_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
`ifdef SEQ_GEN_GAP_EN
        GAP: begin
          if (gap_cnt == '0) begin
            a_valid <= 1'b1;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator with default parameters.
// Stimulus pushes expected output events (bit or done pulse, with the
// absolute cycle they must appear in); the monitor pops on every output
// event and compares.
module tb_sequence_generator;

`ifdef SEQ_GEN_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       start = 1'b0;
  logic [3:0] rep = 4'd0;
  logic       A, a_valid, busy, done;

  typedef struct {
    int   cyc;
    bit   is_done;
    logic a;
    logic busy;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  sequence_generator dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .pat_in  (pat_in),
    .start   (start),
    .rep     (rep),
    .A       (A),
    .a_valid (a_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (!a_valid && A !== 1'b0) begin
        n_mis++;
        $display("FAIL a_zero cyc=%0d: A=%b with a_valid=0, required A=0", cyc, A);
      end
      if (a_valid === 1'b1 || done === 1'b1) begin
        if (q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_event cyc=%0d: a_valid=%b done=%b A=%b, required no event",
                   cyc, a_valid, done, A);
        end else begin
          e = q.pop_front();
          n_vec++;
          if (e.cyc != cyc || e.is_done != done || e.is_done == a_valid ||
              (!e.is_done && A !== e.a) || busy !== e.busy) begin
            n_mis++;
            $display("FAIL event: got cyc=%0d done=%b a_valid=%b A=%b busy=%b, required cyc=%0d done=%b a_valid=%b A=%b busy=%b",
                     cyc, done, a_valid, A, busy, e.cyc, e.is_done, !e.is_done, e.a, e.busy);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Issues start on the next falling edge and queues the expected events.
  // partial: queue only the first two bits (transmission will be aborted).
  task automatic issue(input logic [3:0] pat_exp, input int r, input bit do_load,
                       input logic [3:0] p_in, input bit partial);
    int   c;
    exp_t e;
    @(negedge clk);
    c      = cyc;
    start  = 1'b1;
    rep    = 4'(r);
    load   = do_load;
    pat_in = p_in;
    if (r == 0) begin
      e = '{cyc: c + 1, is_done: 1'b1, a: 1'b0, busy: 1'b0};
      q.push_back(e);
    end else begin
      for (int rr = 0; rr < r; rr++) begin
        for (int b = 0; b < 4; b++) begin
          if (!partial || (rr * 4 + b) < 2) begin
            e = '{cyc: c + 1 + rr * (4 + GAP) + b, is_done: 1'b0, a: pat_exp[3-b], busy: 1'b1};
            q.push_back(e);
          end
        end
      end
      if (!partial) begin
        e = '{cyc: c + 1 + r * 4 + (r - 1) * GAP, is_done: 1'b1, a: 1'b0, busy: 1'b0};
        q.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
    load  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk("reset_A", 32'(A), 32'd0);
    chk("reset_a_valid", 32'(a_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Single repetition of the default pattern
    issue(4'b1101, 1, 1'b0, 4'b0000, 1'b0);
    drain();

    // Three repetitions: 1101 1101 1101 (gapped when the macro is on)
    issue(4'b1101, 3, 1'b0, 4'b0000, 1'b0);
    drain();

    // Two repetitions
    issue(4'b1101, 2, 1'b0, 4'b0000, 1'b0);
    drain();

    // Load together with start: new pattern sent
    issue(4'b0110, 1, 1'b1, 4'b0110, 1'b0);
    drain();

    // Load and start pulsed during SEND are ignored
    issue(4'b0110, 1, 1'b0, 4'b0000, 1'b0);
    start  = 1'b1;
    rep    = 4'd3;
    load   = 1'b1;
    pat_in = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    load  = 1'b0;
    drain();
    issue(4'b0110, 1, 1'b0, 4'b0000, 1'b0);
    drain();

    // rep = 0: done only, one cycle after start
    issue(4'b0110, 0, 1'b0, 4'b0000, 1'b0);
    drain();

    // Maximum repeat count
    issue(4'b0110, 15, 1'b0, 4'b0000, 1'b0);
    drain();

    // Reset after two bits of rep=2
    issue(4'b0110, 2, 1'b0, 4'b0000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_a_valid", 32'(a_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_A", 32'(A), 32'd0);
    chk("abort_a_valid", 32'(a_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL abort_bits: %0d pre-reset bits not seen, required 0", q.size());
      q.delete();
    end
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    // First edge after release accepts start; pattern is back to PAT_INIT
    issue(4'b1101, 1, 1'b0, 4'b0000, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
